// File: rtl/mdu_pkg.sv
// Shared types, widths and op-decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used both to take magnitudes
// of signed operands and to restore the sign of finished results.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);

    assign fixed = negate ? -value : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one 2*WIDTH accumulator.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    mdu_state_t         state;
    mdu_state_t         state_nxt;
    mdu_op_t            op_in;
    mdu_op_t            op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   result_q;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_zero;
    logic               div_ovf;
    logic               fast;
    logic               accept;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH:0]     div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_sel;

    assign op_in  = mdu_op_t'(op);
    assign sign_a = is_signed_a(op_in) & src_a[WIDTH-1];
    assign sign_b = is_signed_b(op_in) & src_b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (
        .value  (src_a),
        .negate (sign_a),
        .fixed  (mag_a)
    );

    mdu_sign_fix #(.W(WIDTH)) u_mag_b (
        .value  (src_b),
        .negate (sign_b),
        .fixed  (mag_b)
    );

    assign div_zero = is_div(op_in) && (src_b == '0);
    assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                   && (src_a == {1'b1, {(WIDTH-1){1'b0}}})
                   && (src_b == '1);
    assign fast     = div_zero | div_ovf;
    assign accept   = (state == IDLE) && start && !kill;

    // Multiply: add into the upper half, then shift the whole product right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, opnd & {WIDTH{acc[0]}}};
    // Divide: partial remainder shifted left with the next dividend bit.
    assign div_tmp  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_tmp - {1'b0, opnd};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = fast ? FINISH : CALC;
            CALC: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            op_q     <= OP_MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        cnt     <= '0;
                        neg_res <= fast ? 1'b0 : (sign_a ^ sign_b);
                        neg_rem <= fast ? 1'b0 : sign_a;
                        opnd    <= is_div(op_in) ? mag_b : mag_a;
                        if (div_zero) begin
                            acc <= {src_a, {WIDTH{1'b1}}};
                        end else if (div_ovf) begin
                            acc <= {{WIDTH{1'b0}}, src_a};
                        end else if (is_div(op_in)) begin
                            acc <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!is_div(op_q)) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    if (!kill) result_q <= res_sel;
                end
                default: ;
            endcase
        end
    end

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .negate (neg_res),
        .fixed  (prod_fix)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value  (acc[WIDTH-1:0]),
        .negate (neg_res),
        .fixed  (quo_fix)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate (neg_rem),
        .fixed  (rem_fix)
    );

    always_comb begin
        res_sel = '0;
        unique case (op_q)
            OP_MUL:                       res_sel = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res_sel = quo_fix;
            default:                      res_sel = rem_fix;
        endcase
    end

    assign busy   = (state == CALC);
    assign done   = (state == FINISH) && !kill;
    assign result = done ? res_sel : result_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.
- Consumes decoded M-extension ops: funct3 with funct7 = 0000001, ALUOp = 10.
- Asserts busy while computing so hazard logic can stall IF/ID/EX.
- Produces a registered 32-bit result and a one-cycle done pulse for EX/MEM writeback.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- kill  input  1  pipeline flush; aborts the current operation.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  WIDTH  rs1 value (multiplicand / dividend).
- src_b  input  WIDTH  rs2 value (multiplier / divisor).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  WIDTH  registered result; held until the next done.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 and kill=0: latch op and operands, go to CALC, busy=1 from the next cycle.
  - start=1 and kill=1 in the same cycle: kill wins; stay IDLE.
- Sign pre-processing at start:
  - Operands that the op treats as signed are converted to magnitudes.
  - Negate flags are latched.
  - MULHSU: src_a signed, src_b unsigned.
- Fast path, DIV/DIVU/REM/REMU only:
  - Divide by zero (src_b=0): quotient = all ones, remainder = src_a.
  - Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Go straight to FINISH; done is asserted in cycle 1 after start.
- CALC, multiply:
  - Radix-2 shift-add over a 2*WIDTH product register.
  - Exactly WIDTH iterations.
- CALC, divide:
  - Restoring shift-subtract producing quotient and remainder.
  - Exactly WIDTH iterations.
- Counter: loads 0 at start, increments each CALC cycle, leaves CALC when it reaches WIDTH-1.
- FINISH (one cycle):
  - Apply sign correction.
    - Product: negate when the operand signs differ.
    - Quotient: negate when the signs differ.
    - Remainder: takes the dividend's sign.
  - Select the result:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the result, pulse done=1, busy=0, return to IDLE.
- Latency:
  - start sampled at cycle 0; busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1 (33).
  - Fast path: busy=0 throughout; done in cycle 1.
- Back-to-back: a new start is accepted in the cycle after done.
- start while busy is ignored; operands and op are not re-latched.
- kill in CALC or FINISH:
  - Next cycle returns to IDLE with busy=0, done=0.
  - result keeps its previous value; no done pulse for the killed operation.
- reset mid-operation: returns to reset values on the next edge, regardless of start/kill.
- Inputs may change freely after the start cycle.
- All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH product.

Decomposition:
- mdu_pkg holds:
  - WIDTH constant.
  - mdu_op_t enum for the 8 funct3 encodings.
  - mdu_state_t enum {IDLE, CALC, FINISH}.
  - Helper functions is_div(op) and is_signed_a(op)/is_signed_b(op).
- One sub-module, mdu_sign_fix: combinational magnitude and negation helper, instantiated for pre-processing and for final correction.
- The iteration datapath stays in mul_div_unit.

Test Plan:
- Multiply, basic:
  - MUL src_a=7, src_b=0xFFFFFFFD (-3) -> busy cycles 1..32, done at cycle 33, result=0xFFFFFFEB.
- Multiply, high halves:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Divide, signed and unsigned:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at cycle 33.
- Fast path:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each: done at cycle 1, busy never high.
- Control:
  - kill at cycle 10 of MUL -> busy=0 at cycle 11, no done, result unchanged.
  - start with kill in IDLE -> no operation.
  - start pulsed at cycle 5 of an in-flight DIVU -> ignored; original result returned at cycle 33.
- Reset and back-to-back:
  - reset at cycle 20 -> busy=0, done=0, result=0 next cycle.
  - start in the cycle after done -> second result correct at +33.
